// File: rtl/ldst_pkg.sv
// Shared definitions for the D-format load/store sequencer: state encodings,
// ALU/PC select codes, addressing modes and the control-word layout.
package ldst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_ADDR = 3'b001,
        ST_MEM  = 3'b010,
        ST_WB   = 3'b011,
        ST_ERR  = 3'b100
    } state_e;

    localparam logic [4:0] FSEL_ADD   = 5'b01000;
    localparam logic [4:0] FSEL_PASSA = 5'b00000;
    localparam logic [1:0] PSEL_INC   = 2'b01;

    localparam logic [1:0] MODE_OFFSET = 2'b00;
    localparam logic [1:0] MODE_POST   = 2'b01;
    localparam logic [1:0] MODE_RSVD   = 2'b10;
    localparam logic [1:0] MODE_PRE    = 2'b11;

    localparam logic [8:0] LDST_OPC = 9'b111110000;

    // Bit positions inside the 31-bit control word, LSB first.
    localparam int CW_W      = 31;
    localparam int CW_SL     = 0;
    localparam int CW_PCSEL  = 1;
    localparam int CW_BSEL   = 2;
    localparam int CW_EN_PC  = 3;
    localparam int CW_EN_B   = 4;
    localparam int CW_EN_ALU = 5;
    localparam int CW_EN_MEM = 6;
    localparam int CW_RAMW   = 7;
    localparam int CW_REGW   = 8;
    localparam int CW_FSEL   = 9;
    localparam int CW_SB     = 14;
    localparam int CW_SA     = 19;
    localparam int CW_DA     = 24;
    localparam int CW_PSEL   = 29;

    typedef struct packed {
        logic [1:0] psel;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fsel;
        logic       regW;
        logic       ramW;
        logic       enMem;
        logic       enAlu;
        logic       enB;
        logic       enPc;
        logic       bsel;
        logic       pcsel;
        logic       sl;
    } ctrl_word_t;

endpackage

// File: rtl/ldst_decode.sv
// Field decoder: judges whether the offered word is a supported load/store and
// splits the latched instruction into register numbers, mode and immediate.
module ldst_decode
    import ldst_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int IMM_W    = 9,
    parameter int SIGN_EXT = 1
) (
    input  logic [31:0]       offer_i,
    input  logic [31:0]       ir_i,
    output logic              supported_o,
    output logic              is_load_o,
    output logic [1:0]        mode_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rn_o,
    output logic [DATA_W-1:0] k_o
);

    logic [IMM_W-1:0] imm;
    logic             extBit;
    logic             unusedBits;

    assign supported_o = (offer_i[31:23] == LDST_OPC) && !offer_i[21]
                         && (offer_i[11:10] != MODE_RSVD);

    assign is_load_o = ir_i[22];
    assign mode_o    = ir_i[11:10];
    assign rt_o      = ir_i[4:0];
    assign rn_o      = ir_i[9:5];

    // The immediate is taken from the latched word only, so K stays stable in IDLE.
    assign imm    = ir_i[12 +: IMM_W];
    assign extBit = (SIGN_EXT != 0) ? imm[IMM_W-1] : 1'b0;
    assign k_o    = {{(DATA_W - IMM_W){extBit}}, imm};

    assign unusedBits = ^{offer_i[22], offer_i[20:12], offer_i[9:0], ir_i[31:23], ir_i[21]};

endmodule

// File: rtl/ldst_sequencer.sv
// Multi-cycle sequencer for D-format loads/stores: IDLE -> ADDR -> MEM -> (WB),
// producing one control word per cycle, with a memory-ready timeout into ERR.
module ldst_sequencer
    import ldst_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int IMM_W    = 9,
    parameter int SIGN_EXT = 1,
    parameter int WAIT_MAX = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    output logic              ready,
    input  logic              mem_ready,
    output logic [CW_W-1:0]   controlword,
    output logic [DATA_W-1:0] K,
    output logic [2:0]        state,
    output logic              done,
    output logic              illegal,
    output logic              fault
);

    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic             fault_q, fault_d;
    logic             illegal_q, illegal_d;

    logic             supported;
    logic             isLoad;
    logic [1:0]       mode;
    logic [4:0]       rt;
    logic [4:0]       rn;
    logic [4:0]       addrFsel;
    logic             needsWb;
    ctrl_word_t       cw;

    ldst_decode #(
        .DATA_W  (DATA_W),
        .IMM_W   (IMM_W),
        .SIGN_EXT(SIGN_EXT)
    ) u_decode (
        .offer_i    (instruction),
        .ir_i       (ir_q),
        .supported_o(supported),
        .is_load_o  (isLoad),
        .mode_o     (mode),
        .rt_o       (rt),
        .rn_o       (rn),
        .k_o        (K)
    );

    // Post-index addresses memory with the raw base; the other modes add K first.
    always_comb begin
        addrFsel = FSEL_ADD;
        needsWb  = 1'b0;
        unique case (mode)
            MODE_OFFSET: begin
                addrFsel = FSEL_ADD;
                needsWb  = 1'b0;
            end
            MODE_POST: begin
                addrFsel = FSEL_PASSA;
                needsWb  = 1'b1;
            end
            MODE_PRE: begin
                addrFsel = FSEL_ADD;
                needsWb  = 1'b1;
            end
            default: begin
                addrFsel = FSEL_ADD;
                needsWb  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            waitCnt_q <= '0;
            fault_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            waitCnt_q <= waitCnt_d;
            fault_q   <= fault_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        waitCnt_d = waitCnt_q;
        fault_d   = fault_q;
        illegal_d = 1'b0;
        cw        = '0;
        done      = 1'b0;
        ready     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (instr_valid) begin
                    if (supported) begin
                        ir_d    = instruction;
                        state_d = ST_ADDR;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end

            ST_ADDR: begin
                cw.sa     = rn;
                cw.fsel   = addrFsel;
                cw.enAlu  = 1'b1;
                cw.bsel   = 1'b1;
                cw.pcsel  = 1'b1;
                waitCnt_d = '0;
                state_d   = ST_MEM;
            end

            ST_MEM: begin
                cw.sa    = rn;
                cw.sb    = rt;
                cw.da    = rt;
                cw.fsel  = addrFsel;
                cw.bsel  = 1'b1;
                cw.pcsel = 1'b1;
                if (isLoad) begin
                    cw.enMem = 1'b1;
                    cw.regW  = mem_ready;
                end else begin
                    cw.enB  = 1'b1;
                    cw.ramW = 1'b1;
                end
                if (mem_ready) begin
                    if (needsWb) begin
                        state_d = ST_WB;
                    end else begin
                        done    = 1'b1;
                        cw.enPc = 1'b1;
                        cw.psel = PSEL_INC;
                        state_d = ST_IDLE;
                    end
                end else if (waitCnt_q == WAIT_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end

            // Base update comes after the load's write, so with Rt==Rn the base wins.
            ST_WB: begin
                cw.da    = rn;
                cw.sa    = rn;
                cw.fsel  = FSEL_ADD;
                cw.bsel  = 1'b1;
                cw.enAlu = 1'b1;
                cw.regW  = 1'b1;
                cw.enPc  = 1'b1;
                cw.psel  = PSEL_INC;
                cw.pcsel = 1'b1;
                done     = 1'b1;
                state_d  = ST_IDLE;
            end

            ST_ERR: begin
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        controlword                   = '0;
        controlword[CW_PSEL +: 2]     = cw.psel;
        controlword[CW_DA +: 5]       = cw.da;
        controlword[CW_SA +: 5]       = cw.sa;
        controlword[CW_SB +: 5]       = cw.sb;
        controlword[CW_FSEL +: 5]     = cw.fsel;
        controlword[CW_REGW]          = cw.regW;
        controlword[CW_RAMW]          = cw.ramW;
        controlword[CW_EN_MEM]        = cw.enMem;
        controlword[CW_EN_ALU]        = cw.enAlu;
        controlword[CW_EN_B]          = cw.enB;
        controlword[CW_EN_PC]         = cw.enPc;
        controlword[CW_BSEL]          = cw.bsel;
        controlword[CW_PCSEL]         = cw.pcsel;
        controlword[CW_SL]            = cw.sl;
    end

    assign state   = state_q;
    assign fault   = fault_q;
    assign illegal = illegal_q;

endmodule
